satatrn_txsched: RTL and testbench



---
 rtl/satatrn_pkg.sv | 18 +
 rtl/satatrn_txsched_chunk.sv | 49 ++++
 rtl/satatrn_txsched.sv | 214 +++++++++++++++++++++
 tb/tb_satatrn_txsched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/satatrn_pkg.sv
// satatrn_pkg: shared state encoding and Data FIS constants for the SATA transport TX path.
`default_nettype none

package satatrn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACT  = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_LINK = 2'd3
  } txsched_state_t;

  localparam logic [7:0] FIS_DATA       = 8'h46;
  localparam int         MAX_FIS_DWORDS = 2048;

endpackage

`default_nettype wire

// File: rtl/satatrn_txsched_chunk.sv
// satatrn_txsched_chunk: per-FIS burst size, word counter and last-word flag.
`default_nettype none

module satatrn_txsched_chunk
  import satatrn_pkg::*;
#(
  parameter int LGLEN    = 24,
  parameter int LGMAXFIS = $clog2(MAX_FIS_DWORDS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LGLEN-1:0]   remaining,
  input  logic               advance,
  output logic [LGMAXFIS:0]  burst,
  output logic               more,
  output logic               last_next
);

  // Compare in a width that holds both the command length and 2^LGMAXFIS.
  localparam int CW = (LGLEN > LGMAXFIS + 1) ? LGLEN : LGMAXFIS + 1;

  logic [CW-1:0]     rem_wide;
  logic [CW-1:0]     max_wide;
  logic [LGMAXFIS:0] burst_load;
  logic [LGMAXFIS:0] wcount;

  assign rem_wide   = CW'(remaining);
  assign max_wide   = CW'(1) << LGMAXFIS;
  assign burst_load = (rem_wide >= max_wide) ? max_wide[LGMAXFIS:0] : rem_wide[LGMAXFIS:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      burst  <= '0;
      wcount <= '0;
    end else if (load) begin
      burst  <= burst_load;
      wcount <= '0;
    end else if (advance) begin
      wcount <= wcount + (LGMAXFIS+1)'(1);
    end
  end

  assign more      = (wcount < burst);
  assign last_next = ((wcount + (LGMAXFIS+1)'(1)) == burst);

endmodule

`default_nettype wire

// File: rtl/satatrn_txsched.sv
// satatrn_txsched: splits a DMA write into Data FIS payloads gated by DMA Activate and link acks.
// Optional link-acknowledge watchdog: define SATATRN_TXSCHED_TIMEOUT_EN.
`default_nettype none

module satatrn_txsched
  import satatrn_pkg::*;
#(
  parameter int LGLEN     = 24,
  parameter int LGMAXFIS  = $clog2(MAX_FIS_DWORDS),
  parameter int LGTIMEOUT = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [LGLEN-1:0] i_cfg_len,
  input  logic             i_dma_activate,
  input  logic             i_abort,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [31:0]      i_s_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [31:0]      o_m_data,
  output logic             o_m_last,
  output logic             o_txgate,
  input  logic             i_link_done,
  input  logic             i_link_err,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  txsched_state_t    state, state_nx;
  logic [LGLEN-1:0]  remaining, remaining_nx;
  logic              abort_pend, abort_pend_nx;
  logic              txgate, txgate_nx;
  logic              done, done_nx;
  logic              err, err_nx;
  logic              m_valid, m_valid_nx;
  logic              m_last, m_last_nx;
  logic [31:0]       m_data;

  logic              chunk_load;
  logic [LGMAXFIS:0] burst_len;
  logic              chunk_more;
  logic              chunk_last_next;
  logic              in_acc;
  logic              out_acc;
  logic              wd_expired;

  satatrn_txsched_chunk #(
    .LGLEN    (LGLEN),
    .LGMAXFIS (LGMAXFIS)
  ) u_chunk (
    .clk       (i_clk),
    .reset     (i_reset),
    .load      (chunk_load),
    .remaining (remaining),
    .advance   (in_acc),
    .burst     (burst_len),
    .more      (chunk_more),
    .last_next (chunk_last_next)
  );

  assign o_s_ready = (state == ST_SEND) && (!m_valid || i_m_ready) && chunk_more;
  assign in_acc    = o_s_ready && i_s_valid;
  assign out_acc   = m_valid && i_m_ready;

`ifdef SATATRN_TXSCHED_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] wd_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || state != ST_WAIT_LINK) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + LGTIMEOUT'(1);
    end
  end

  assign wd_expired = &wd_count;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(LGTIMEOUT);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    remaining_nx  = remaining;
    abort_pend_nx = abort_pend;
    txgate_nx     = txgate;
    done_nx       = 1'b0;
    err_nx        = 1'b0;
    chunk_load    = 1'b0;
    m_valid_nx    = m_valid;
    m_last_nx     = m_last;

    if (in_acc) begin
      m_valid_nx = 1'b1;
      m_last_nx  = chunk_last_next;
    end else if (out_acc) begin
      m_valid_nx = 1'b0;
      m_last_nx  = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        abort_pend_nx = 1'b0;
        if (i_cfg_valid) begin
          remaining_nx = i_cfg_len;
          if (i_cfg_len == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = ST_WAIT_ACT;
          end
        end
      end

      ST_WAIT_ACT: begin
        if (i_abort) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else if (i_dma_activate) begin
          chunk_load = 1'b1;
          txgate_nx  = 1'b1;
          state_nx   = ST_SEND;
        end
      end

      ST_SEND: begin
        // The arbiter cannot cut a frame short, so an abort waits for the last handshake.
        if (i_abort) begin
          abort_pend_nx = 1'b1;
        end
        if (out_acc && m_last) begin
          txgate_nx = 1'b0;
          if (abort_pend || i_abort) begin
            err_nx        = 1'b1;
            abort_pend_nx = 1'b0;
            state_nx      = ST_IDLE;
          end else begin
            state_nx = ST_WAIT_LINK;
          end
        end
      end

      ST_WAIT_LINK: begin
        if (i_abort) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else if (i_link_done) begin
          if (i_link_err) begin
            err_nx   = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            remaining_nx = remaining - LGLEN'(burst_len);
            if (remaining_nx == '0) begin
              done_nx  = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_WAIT_ACT;
            end
          end
        end else if (wd_expired) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      abort_pend <= 1'b0;
      txgate     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      abort_pend <= abort_pend_nx;
      txgate     <= txgate_nx;
      done       <= done_nx;
      err        <= err_nx;
      m_valid    <= m_valid_nx;
      m_last     <= m_last_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (in_acc) begin
      m_data <= i_s_data;
    end
  end

  assign o_cfg_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);
  assign o_m_valid   = m_valid;
  assign o_m_last    = m_last;
  assign o_m_data    = (state == ST_IDLE) ? 32'd0 : m_data;
  assign o_txgate    = txgate;
  assign o_done      = done;
  assign o_err       = err;

endmodule

`default_nettype wire

// File: tb/tb_satatrn_txsched.sv
// tb_satatrn_txsched: randomized bench with a queue-based transfer model for satatrn_txsched.
`default_nettype none

module tb_satatrn_txsched;

  localparam int LGLEN    = 24;
  localparam int LGMAXFIS = 11;
  localparam int MAXFIS   = 2048;

  logic        clk;
  logic        i_reset;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [23:0] i_cfg_len;
  logic        i_dma_activate;
  logic        i_abort;
  logic        i_s_valid;
  logic        o_s_ready;
  logic [31:0] i_s_data;
  logic        o_m_valid;
  logic        i_m_ready;
  logic [31:0] o_m_data;
  logic        o_m_last;
  logic        o_txgate;
  logic        i_link_done;
  logic        i_link_err;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  satatrn_txsched #(
    .LGLEN     (LGLEN),
    .LGMAXFIS  (LGMAXFIS),
    .LGTIMEOUT (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_len      (i_cfg_len),
    .i_dma_activate (i_dma_activate),
    .i_abort        (i_abort),
    .i_s_valid      (i_s_valid),
    .o_s_ready      (o_s_ready),
    .i_s_data       (i_s_data),
    .o_m_valid      (o_m_valid),
    .i_m_ready      (i_m_ready),
    .o_m_data       (o_m_data),
    .o_m_last       (o_m_last),
    .o_txgate       (o_txgate),
    .i_link_done    (i_link_done),
    .i_link_err     (i_link_err),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: source words of the command, expected output order, FIS progress.
  logic [31:0] src_mem[$];
  int          src_idx;
  int          exp_idx;
  bit          in_fis;
  int          fis_size;
  int          fis_cnt;
  int          stall_left;
  bit          hold_pend;
  logic [31:0] hold_data;
  logic        hold_last;
  bit          seen_done;
  bit          seen_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit s_fire;
    bit m_fire;
    @(negedge clk);
    s_fire = i_s_valid && o_s_ready;
    m_fire = o_m_valid && i_m_ready;
    if (hold_pend) begin
      check("hold_valid", o_m_valid, 1);
      check("hold_data", o_m_data, hold_data);
      check("hold_last", o_m_last, hold_last);
    end
    hold_pend = o_m_valid && !i_m_ready;
    hold_data = o_m_data;
    hold_last = o_m_last;
    if (in_fis) begin
      check("txgate_high", o_txgate, 1);
    end else begin
      check("txgate_low", o_txgate, 0);
      check("mvalid_low", o_m_valid, 0);
    end
    if (m_fire) begin
      if (!in_fis) begin
        check("stray_word", 1, 0);
      end else begin
        check("word_data", o_m_data, (exp_idx < src_mem.size()) ? src_mem[exp_idx] : 32'hdeadbeef);
        check("word_last", o_m_last, (fis_cnt == fis_size - 1));
        exp_idx++;
        fis_cnt++;
      end
    end
    seen_done = o_done;
    seen_err  = o_err;
    check("done_err_excl", o_done && o_err, 0);
    @(posedge clk);
    #1;
    if (s_fire) src_idx++;
    if (stall_left > 0) begin
      i_m_ready = 1'b0;
      stall_left--;
    end else begin
      i_m_ready = ($urandom_range(0, 3) != 0);
    end
    i_s_valid = (src_idx < src_mem.size()) && ($urandom_range(0, 3) != 0);
    i_s_data  = (src_idx < src_mem.size()) ? src_mem[src_idx] : $urandom;
  endtask

  task automatic issue_cfg(input int len);
    src_mem.delete();
    src_idx = 0;
    exp_idx = 0;
    for (int i = 0; i < len; i++) src_mem.push_back($urandom);
    check("cfg_ready", o_cfg_ready, 1);
    i_cfg_valid = 1'b1;
    i_cfg_len   = 24'(len);
    tick();
    i_cfg_valid = 1'b0;
  endtask

  // err_fis/abort_fis/tmo_fis select which FIS (0-based) gets the fault; -1 disables it.
  task automatic run_cmd(input int len, input int err_fis, input int abort_fis,
                         input int abort_word, input int stall_at, input int tmo_fis);
    int rem;
    int size;
    int k;
    int guard;
    int n;
    bit aborted;
    bit stalled;
    issue_cfg(len);
    if (len == 0) begin
      tick();
      check("zero_done", seen_done, 1);
      check("zero_err", seen_err, 0);
      tick();
      check("zero_done_once", seen_done, 0);
      return;
    end
    rem = len;
    k = 0;
    while (rem > 0) begin
      size = (rem > MAXFIS) ? MAXFIS : rem;
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("wait_act_quiet", {seen_done, seen_err}, 0);
      end
      i_dma_activate = 1'b1;
      tick();
      i_dma_activate = 1'b0;
      in_fis   = 1'b1;
      fis_size = size;
      fis_cnt  = 0;
      aborted  = 1'b0;
      stalled  = 1'b0;
      guard    = 0;
      while (fis_cnt < size && guard < 20000) begin
        tick();
        guard++;
        i_abort = 1'b0;
        if (k == abort_fis && !aborted && fis_cnt >= abort_word) begin
          i_abort = 1'b1;
          aborted = 1'b1;
        end
        if (k == 0 && stall_at >= 0 && !stalled && fis_cnt >= stall_at) begin
          stall_left = 10;
          stalled    = 1'b1;
        end
      end
      i_abort = 1'b0;
      in_fis  = 1'b0;
      check("fis_words", fis_cnt, size);
      if (fis_cnt < size) return;
      if (k == abort_fis) begin
        tick();
        check("abort_err", seen_err, 1);
        check("abort_nodone", seen_done, 0);
        check("abort_idle", o_busy, 0);
        return;
      end
      if (k == tmo_fis) begin
        n = 0;
        do begin
          tick();
          n++;
        end while (!seen_err && n < 40);
        check("tmo_err", seen_err, 1);
        check("tmo_cycles", (n >= 15 && n <= 18), 1);
        check("tmo_idle", o_busy, 0);
        return;
      end
      repeat ($urandom_range(0, 4)) begin
        i_dma_activate = $urandom_range(0, 1);
        tick();
        check("wait_link_quiet", {seen_done, seen_err}, 0);
      end
      i_dma_activate = 1'b0;
      i_link_done = 1'b1;
      i_link_err  = (k == err_fis);
      tick();
      i_link_done = 1'b0;
      i_link_err  = 1'b0;
      tick();
      rem -= size;
      if (k == err_fis) begin
        check("link_err", seen_err, 1);
        check("link_err_nodone", seen_done, 0);
        check("link_err_idle", o_busy, 0);
        return;
      end
      check("done_pulse", seen_done, (rem == 0));
      check("no_err", seen_err, 0);
      k++;
    end
    tick();
    check("done_once", seen_done, 0);
    check("idle_data", o_m_data, 0);
    check("idle_busy", o_busy, 0);
  endtask

  initial begin
    int guard;
    i_reset        = 1'b1;
    i_cfg_valid    = 1'b0;
    i_cfg_len      = '0;
    i_dma_activate = 1'b0;
    i_abort        = 1'b0;
    i_s_valid      = 1'b0;
    i_s_data       = '0;
    i_m_ready      = 1'b1;
    i_link_done    = 1'b0;
    i_link_err     = 1'b0;
    src_idx = 0; exp_idx = 0; in_fis = 0; fis_size = 0; fis_cnt = 0;
    stall_left = 0; hold_pend = 0; seen_done = 0; seen_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", o_m_valid, 0);
    check("rst_mlast", o_m_last, 0);
    check("rst_txgate", o_txgate, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_ready", o_cfg_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_m_data, 0);
    i_reset = 1'b0;
    tick();

    run_cmd(5, -1, -1, 0, -1, -1);
    run_cmd(4100, -1, -1, 0, -1, -1);
    run_cmd(0, -1, -1, 0, -1, -1);
    run_cmd(40, -1, -1, 0, 7, -1);
    run_cmd(3000, 1, -1, 0, -1, -1);
    run_cmd(7, -1, -1, 0, -1, -1);
    run_cmd(10, -1, 0, 3, -1, -1);
    for (int r = 0; r < 6; r++) begin
      run_cmd($urandom_range(1, 2600), -1, -1, 0, ($urandom_range(0, 1) != 0) ? 5 : -1, -1);
    end
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
    run_cmd(6, -1, -1, 0, -1, 0);
`endif

    // Reset in the middle of a FIS must drop the output stage immediately.
    issue_cfg(20);
    i_dma_activate = 1'b1;
    tick();
    i_dma_activate = 1'b0;
    in_fis   = 1'b1;
    fis_size = 20;
    fis_cnt  = 0;
    guard    = 0;
    while (fis_cnt < 3 && guard < 200) begin
      tick();
      guard++;
    end
    check("pre_reset_words", fis_cnt >= 3, 1);
    i_reset = 1'b1;
    tick();
    check("midrst_mvalid", o_m_valid, 0);
    check("midrst_txgate", o_txgate, 0);
    check("midrst_ready", o_cfg_ready, 1);
    i_reset   = 1'b0;
    in_fis    = 1'b0;
    hold_pend = 1'b0;
    tick();
    check("postrst_busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
